// File: rtl/notch_analyzer_pkg.sv
// Shared constants and FSM encoding for the notch response analyzer.
// Latency: n/a (declarations only); backpressure: n/a.
package notch_analyzer_pkg;

    localparam logic [15:0] HALF_POWER_Q13 = 16'h16A1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/half_power_threshold.sv
// Half-power (-3 dB) threshold: (ref_magnitude * 0x16A1) >> FIXED_Q, truncated.
// Latency: combinational; backpressure: none.
module half_power_threshold
    import notch_analyzer_pkg::*;
#(
    parameter int MAG_BITS = 16,
    parameter int FIXED_Q  = 13
) (
    input  logic [MAG_BITS-1:0] ref_magnitude,
    output logic [MAG_BITS-1:0] thr
);

    logic [MAG_BITS+15:0] product;
    logic                 unused_bits;

    assign product = {16'b0, ref_magnitude} * {{MAG_BITS{1'b0}}, HALF_POWER_Q13};
    assign thr     = product[FIXED_Q +: MAG_BITS];

    // The Q13 constant is below 1.0, so the bits above the window are always zero.
    assign unused_bits = ^{product[FIXED_Q-1:0], product[MAG_BITS+15:MAG_BITS+FIXED_Q]};

endmodule

// File: rtl/notch_response_analyzer.sv
// Tracks DC reference, minimum-magnitude bin and -3 dB stopband over one sweep.
// Latency: results registered on the sampling edge, done one cycle after the last beat; no backpressure (one bin/clk).
module notch_response_analyzer
    import notch_analyzer_pkg::*;
#(
    parameter int CONFIG_SIZE = 16,
    parameter int MAG_BITS    = 16,
    parameter int FIXED_Q     = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CONFIG_SIZE-1:0] config_nfft,
    input  logic [MAG_BITS-1:0]    tf_val_magnitude,
    input  logic [MAG_BITS-1:0]    tf_val_phase,
    input  logic                   tf_val_valid,
    output logic [MAG_BITS-1:0]    ref_magnitude,
    output logic [CONFIG_SIZE-1:0] notch_idx,
    output logic [MAG_BITS-1:0]    notch_magnitude,
    output logic [MAG_BITS-1:0]    notch_phase,
    output logic [CONFIG_SIZE-1:0] stop_lo_idx,
    output logic [CONFIG_SIZE-1:0] stop_hi_idx,
    output logic [CONFIG_SIZE-1:0] stopband_bins,
    output logic                   busy,
    output logic                   done
);

    state_t                 state, state_nxt;
    logic [CONFIG_SIZE-1:0] nfft_q;
    logic [CONFIG_SIZE-1:0] bin_cnt;
    logic [MAG_BITS-1:0]    thr;
    logic                   empty_sweep;
    logic                   beat;
    logic                   last_beat;

    half_power_threshold #(
        .MAG_BITS (MAG_BITS),
        .FIXED_Q  (FIXED_Q)
    ) u_thr (
        .ref_magnitude (ref_magnitude),
        .thr           (thr)
    );

    // A zero-length sweep must not consume a beat, otherwise bin 0 would leak into results.
    assign empty_sweep = (state == RUN) && !start && (nfft_q == '0);
    assign beat        = (state == RUN) && !start && tf_val_valid && (nfft_q != '0);
    assign last_beat   = beat && (bin_cnt == nfft_q - 1'b1);

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:     if (last_beat || empty_sweep) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state == RUN) && (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            nfft_q          <= rst ? '0 : config_nfft;
            bin_cnt         <= '0;
            ref_magnitude   <= '0;
            notch_idx       <= '0;
            notch_magnitude <= '0;
            notch_phase     <= '0;
            stop_lo_idx     <= '0;
            stop_hi_idx     <= '0;
            stopband_bins   <= '0;
        end else if (beat) begin
            bin_cnt <= bin_cnt + 1'b1;
            if (bin_cnt == '0) begin
                ref_magnitude   <= tf_val_magnitude;
                notch_idx       <= '0;
                notch_magnitude <= tf_val_magnitude;
                notch_phase     <= tf_val_phase;
            end else begin
                if (tf_val_magnitude < notch_magnitude) begin
                    notch_idx       <= bin_cnt;
                    notch_magnitude <= tf_val_magnitude;
                    notch_phase     <= tf_val_phase;
                end
                if (tf_val_magnitude < thr) begin
                    stopband_bins <= stopband_bins + 1'b1;
                    stop_hi_idx   <= bin_cnt;
                    if (stopband_bins == '0) stop_lo_idx <= bin_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_notch_response_analyzer.sv
// Directed, table-driven bench for notch_response_analyzer.
module tb_notch_response_analyzer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] config_nfft;
    logic [15:0] tf_val_magnitude;
    logic [15:0] tf_val_phase;
    logic        tf_val_valid;
    logic [15:0] ref_magnitude, notch_idx, notch_magnitude, notch_phase;
    logic [15:0] stop_lo_idx, stop_hi_idx, stopband_bins;
    logic        busy, done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    notch_response_analyzer #(
        .CONFIG_SIZE (16),
        .MAG_BITS    (16),
        .FIXED_Q     (13)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .config_nfft      (config_nfft),
        .tf_val_magnitude (tf_val_magnitude),
        .tf_val_phase     (tf_val_phase),
        .tf_val_valid     (tf_val_valid),
        .ref_magnitude    (ref_magnitude),
        .notch_idx        (notch_idx),
        .notch_magnitude  (notch_magnitude),
        .notch_phase      (notch_phase),
        .stop_lo_idx      (stop_lo_idx),
        .stop_hi_idx      (stop_hi_idx),
        .stopband_bins    (stopband_bins),
        .busy             (busy),
        .done             (done)
    );

    typedef struct {
        int          nfft;
        int          gap;
        logic [15:0] mag [8];
        logic [15:0] e_ref;
        logic [15:0] e_idx;
        logic [15:0] e_nmag;
        logic [15:0] e_lo;
        logic [15:0] e_hi;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV   = 6;
    localparam int FLAT = 99;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ph(input int src, input int k);
        return 16'(32'hA000 + src * 256 + k);
    endfunction

    function automatic logic [15:0] mag_of(input int src, input int k);
        if (src == FLAT) return 16'h2000;
        return vecs[src].mag[k];
    endfunction

    task automatic pulse_start(input int n);
        @(negedge clk);
        rst = 1'b0; start = 1'b1; config_nfft = 16'(n);
        // A beat coincident with start must be dropped.
        tf_val_valid = 1'b1; tf_val_magnitude = 16'h0001; tf_val_phase = 16'hFFFF;
    endtask

    task automatic drive_beat(input logic [15:0] m, input logic [15:0] p);
        @(negedge clk);
        start = 1'b0; tf_val_valid = 1'b1; tf_val_magnitude = m; tf_val_phase = p;
    endtask

    // Streams one sweep after start; checks busy/done framing through to the done pulse.
    task automatic run_sweep(input string name, input int nfft, input int gap, input int src);
        logic early_done, busy_lost;
        early_done = 1'b0; busy_lost = 1'b0;
        pulse_start(nfft);
        for (int k = 0; k < nfft; k++) begin
            if (gap != 0 && k > 0) begin
                @(negedge clk);
                if (done) early_done = 1'b1;
                if (!busy) busy_lost = 1'b1;
                start = 1'b0; tf_val_valid = 1'b0; tf_val_magnitude = 16'h0000;
            end
            @(negedge clk);
            if (done) early_done = 1'b1;
            if (!busy) busy_lost = 1'b1;
            start = 1'b0; tf_val_valid = 1'b1;
            tf_val_magnitude = mag_of(src, k); tf_val_phase = ph(src, k);
        end
        @(negedge clk);
        tf_val_valid = 1'b0;
        check({name, " done_after_last"}, done, 1'b1);
        check({name, " busy_fell"}, busy, 1'b0);
        check({name, " no_early_done"}, early_done, 1'b0);
        check({name, " busy_held"}, busy_lost, 1'b0);
    endtask

    task automatic check_results(input string name, input logic [15:0] r, input logic [15:0] idx,
                                 input logic [15:0] nm, input logic [15:0] np, input logic [15:0] lo,
                                 input logic [15:0] hi, input logic [15:0] cnt);
        check({name, " ref"}, ref_magnitude, r);
        check({name, " notch_idx"}, notch_idx, idx);
        check({name, " notch_mag"}, notch_magnitude, nm);
        check({name, " notch_phase"}, notch_phase, np);
        check({name, " stop_lo"}, stop_lo_idx, lo);
        check({name, " stop_hi"}, stop_hi_idx, hi);
        check({name, " stop_cnt"}, stopband_bins, cnt);
    endtask

    task automatic check_done_drops(input string name);
        @(negedge clk);
        check({name, " done_one_cycle"}, done, 1'b0);
    endtask

    initial begin
        // Basic sweep, thr = 0x16A1.
        vecs[0] = '{nfft: 8, gap: 0,
                    mag: '{16'h2000, 16'h1F00, 16'h1000, 16'h0400, 16'h0100, 16'h0800, 16'h1800, 16'h1F80},
                    e_ref: 16'h2000, e_idx: 4, e_nmag: 16'h0100, e_lo: 2, e_hi: 5, e_cnt: 4};
        // Same data with a valid gap between beats.
        vecs[1] = vecs[0];
        vecs[1].gap = 1;
        // Tied minima at bins 3 and 6: first wins.
        vecs[2] = '{nfft: 8, gap: 0,
                    mag: '{16'h2000, 16'h1F00, 16'h1000, 16'h0300, 16'h0800, 16'h1000, 16'h0300, 16'h1F80},
                    e_ref: 16'h2000, e_idx: 3, e_nmag: 16'h0300, e_lo: 2, e_hi: 6, e_cnt: 5};
        // ref 0x1000 -> thr 0x0B50; bins equal to thr are not stopband.
        vecs[3] = '{nfft: 8, gap: 0,
                    mag: '{16'h1000, 16'h0B50, 16'h0C00, 16'h0FFF, 16'h1000, 16'h2000, 16'h0B50, 16'h0B51},
                    e_ref: 16'h1000, e_idx: 1, e_nmag: 16'h0B50, e_lo: 0, e_hi: 0, e_cnt: 0};
        // nfft=3, ref 0x0100 -> thr 0x00B5, zero-magnitude notch at bin 1.
        vecs[4] = '{nfft: 3, gap: 0,
                    mag: '{16'h0100, 16'h0000, 16'h0050, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                    e_ref: 16'h0100, e_idx: 1, e_nmag: 16'h0000, e_lo: 1, e_hi: 2, e_cnt: 2};
        // DC is the minimum and ties with bin 3; thr = 0x000B.
        vecs[5] = '{nfft: 4, gap: 0,
                    mag: '{16'h0010, 16'h0020, 16'h0030, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
                    e_ref: 16'h0010, e_idx: 0, e_nmag: 16'h0010, e_lo: 0, e_hi: 0, e_cnt: 0};

        rst = 1'b1; start = 1'b0; config_nfft = '0;
        tf_val_valid = 1'b0; tf_val_magnitude = '0; tf_val_phase = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check_results("reset", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

        // Beats in IDLE must not disturb anything.
        for (int k = 0; k < 3; k++) drive_beat(16'h0001, 16'h1234);
        @(negedge clk);
        tf_val_valid = 1'b0;
        check("idle_beats ref", ref_magnitude, 16'h0);
        check("idle_beats busy", busy, 1'b0);

        for (int v = 0; v < NV; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            run_sweep(nm, vecs[v].nfft, vecs[v].gap, v);
            check_results(nm, vecs[v].e_ref, vecs[v].e_idx, vecs[v].e_nmag, ph(v, int'(vecs[v].e_idx)),
                          vecs[v].e_lo, vecs[v].e_hi, vecs[v].e_cnt);
            check_done_drops(nm);
        end

        // Beats in DONE are ignored; results hold.
        for (int k = 0; k < 3; k++) drive_beat(16'h0000, 16'h0000);
        @(negedge clk);
        tf_val_valid = 1'b0;
        check_results("done_hold", vecs[5].e_ref, vecs[5].e_idx, vecs[5].e_nmag, ph(5, 0),
                      vecs[5].e_lo, vecs[5].e_hi, vecs[5].e_cnt);

        // Abort: restart after 3 beats of a different sweep.
        pulse_start(8);
        drive_beat(16'h0005, 16'h0001);
        drive_beat(16'h0001, 16'h0002);
        drive_beat(16'h0002, 16'h0003);
        run_sweep("abort", 8, 0, 0);
        check_results("abort", 16'h2000, 16'd4, 16'h0100, ph(0, 4), 16'd2, 16'd5, 16'd4);
        check_done_drops("abort");

        // Reset mid-sweep wins over start and valid.
        pulse_start(8);
        for (int k = 0; k < 4; k++) drive_beat(mag_of(0, k), ph(0, k));
        @(negedge clk);
        rst = 1'b1; start = 1'b1; tf_val_valid = 1'b1; tf_val_magnitude = 16'h0001;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_mid busy", busy, 1'b0);
        check("rst_mid done", done, 1'b0);
        check_results("rst_mid", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        begin
            logic saw_done;
            saw_done = 1'b0;
            for (int k = 0; k < 10; k++) begin
                drive_beat(16'h0001, 16'h0777);
                if (done) saw_done = 1'b1;
            end
            @(negedge clk);
            tf_val_valid = 1'b0;
            if (done) saw_done = 1'b1;
            check("rst_mid no_done", saw_done, 1'b0);
            check("rst_mid ref_after", ref_magnitude, 16'h0);
        end

        // Long flat sweep: no stopband, DC is the notch.
        run_sweep("flat1275", 1275, 0, FLAT);
        check_results("flat1275", 16'h2000, 16'h0, 16'h2000, ph(FLAT, 0), 16'h0, 16'h0, 16'h0);
        check_done_drops("flat1275");

        // nfft = 0: done two cycles after start, results all zero.
        pulse_start(0);
        @(negedge clk);
        start = 1'b0; tf_val_valid = 1'b1; tf_val_magnitude = 16'h0001;
        check("nfft0 busy", busy, 1'b1);
        check("nfft0 early_done", done, 1'b0);
        @(negedge clk);
        tf_val_valid = 1'b0;
        check("nfft0 done", done, 1'b1);
        check("nfft0 busy_fell", busy, 1'b0);
        check_results("nfft0", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        check_done_drops("nfft0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
